cacheline_adaptor: RTL

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_timeout.sv | 30 +++
 rtl/cacheline_adaptor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types and geometry for the cache-line <-> memory-burst adaptor.
// The optional watchdog in the top level is enabled with CLA_TIMEOUT_EN.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } cla_state_e;

    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);

endpackage

// File: rtl/cla_timeout.sv
// Watchdog for the memory side of a burst: counts busy cycles without a beat.
// Instantiated by cacheline_adaptor only when CLA_TIMEOUT_EN is defined.
module cla_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || !busy) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires in the last allowed quiet cycle so the abort lands on the next edge.
    assign expired = busy && !clear && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit cache line fills/writebacks into 4-beat 64-bit memory bursts.
// Define CLA_TIMEOUT_EN to abort stalled bursts after TIMEOUT_CYCLES quiet cycles.
module cacheline_adaptor
    import cla_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    output logic         resp_o,
    output logic         err_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output logic [63:0]  burst_o,
    input  logic [63:0]  burst_i,
    input  logic         resp_i
);

    cla_state_e         state_q, state_d;
    logic [1:0]         cnt_q;
    logic [LINE_W-1:0]  wline_q;
    logic               busy;
    logic               accept;
    logic               beat;
    logic               timeout;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^address_i[OFFSET_W-1:0];

    assign busy   = (state_q == READ) || (state_q == WRITE);
    assign accept = (state_q == IDLE) && (read_i || write_i);
    assign beat   = busy && resp_i;

`ifdef CLA_TIMEOUT_EN
    logic err_q;

    cla_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept || beat),
        .busy   (busy),
        .expired(timeout)
    );

    // timeout is only ever high while busy, so err_q is set exactly for DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
        end
    end

    assign err_o = err_q && (state_q == DONE);
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (read_i) begin
                    state_d = READ;
                end else if (write_i) begin
                    state_d = WRITE;
                end
            end
            READ, WRITE: begin
                if (timeout) begin
                    state_d = DONE;
                end else if (beat && (cnt_q == 2'(BEATS - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            address_o <= '0;
            wline_q   <= '0;
            line_o    <= '0;
        end else begin
            if (accept) begin
                cnt_q     <= '0;
                address_o <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                if (!read_i) begin
                    wline_q <= line_i;
                end
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
                if (state_q == READ) begin
                    line_o[BEAT_W*cnt_q +: BEAT_W] <= burst_i;
                end
            end
        end
    end

    assign read_o  = (state_q == READ);
    assign write_o = (state_q == WRITE);
    assign resp_o  = (state_q == DONE);
    assign burst_o = wline_q[BEAT_W*cnt_q +: BEAT_W];

endmodule
